wbmic_fifoctl: RTL and testbench
================================

# wbmic_fifoctl

Wishbone-side controller that sequences the MEMs-mic sample FIFO. It gates and decimates the incoming sample stream into the FIFO's write port, and drains the FIFO one sample per bus read. It also manages FIFO flush, overflow halt and threshold interrupts. It sits between the mic front end, the sample FIFO and the system bus.

## Interface
- BW, 12: sample width; 1 ≤ BW ≤ 31.
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high. Clock is i_clk.
- i_smpl_stb  in  1  new sample valid, single-cycle strobe.
- i_smpl_data  in  BW  sample value.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone classic-pipelined strobes.
- i_wb_addr  in  2  register select: 0 CTRL, 1 THRESH, 2 DATA, 3 reserved.
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  acknowledge.
- o_wb_stall  out  1  tied 0.
- o_wb_data  out  32  read data, registered.
- o_fifo_rst  out  1  FIFO reset.
- o_fifo_wr  out  1  FIFO write strobe.
- o_fifo_data  out  BW  FIFO write data.
- o_fifo_rd  out  1  FIFO pop.
- i_fifo_data  in  BW  FIFO head; valid whenever i_fifo_empty_n is high.
- i_fifo_empty_n  in  1  FIFO non-empty.
- i_fifo_status  in  16  {fill[13:0], half_full, empty_n}.
- i_fifo_err  in  1  FIFO overflow. Sticky until FIFO reset.
- o_int  out  1  interrupt, level.

## Operation
- States: IDLE, FLUSH, RUN, HALT. Reset state is IDLE.
- A CTRL write with bit 31 = 0 moves any state to IDLE.
- A CTRL write with bit 31 = 1 goes from IDLE to FLUSH if bit 30 = 1, otherwise to RUN. From HALT it always goes to FLUSH. In FLUSH or RUN it re-enters FLUSH only if bit 30 = 1; otherwise the state is unchanged.
- FLUSH lasts exactly 1 cycle with o_fifo_rst = 1, then moves to RUN.
- RUN moves to HALT when i_fifo_err = 1.
- CTRL write fields: [31] enable, [30] flush, [29] int_en, [27:24] decim. Bits [29] and [27:24] latch on every CTRL write.
- CTRL read: [31] state is RUN or FLUSH, [30] state is HALT, [29] int_en, [28] o_int, [27:24] decim, [23:16] 0, [15:0] i_fifo_status.
- THRESH: bits [13:0] read/write; upper bits read as 0.
- Decimation: counter dcnt (4 bits) loads decim on entry to RUN.
  - In RUN, each i_smpl_stb with dcnt = 0 writes the sample and reloads decim.
  - Otherwise each i_smpl_stb decrements dcnt.
  - Result: one sample written per decim+1 strobes. The first strobe after entry is written when decim = 0.
- Writes happen only in RUN. Samples arriving in IDLE, FLUSH or HALT are dropped.
- DATA read:
  - If i_fifo_empty_n = 1, return {1'b1, zeros, i_fifo_data} and pulse o_fifo_rd for 1 cycle.
  - If empty, return 0 with no pop.
- DATA write, address 3 and THRESH/CTRL side effects on reads: none. Address 3 reads 0.
- o_int = int_en && ((fill ≥ THRESH && THRESH ≠ 0) || state is HALT). fill is i_fifo_status[15:2].
- Reset values: o_wb_ack 0, o_wb_data 0, o_fifo_rst 0, o_fifo_wr 0, o_fifo_rd 0, o_int 0, int_en 0, decim 0, THRESH 0.

## Timing
- Bus latency: o_wb_ack asserts the cycle after i_wb_stb, with o_wb_data valid in that same cycle. Strobes ignored when i_wb_cyc = 0.
- One transaction per clock, back to back.
- Consecutive DATA reads each pop once. The FIFO presents the next head 1 cycle after the pop, so every beat returns a distinct sample.
- o_fifo_rd is registered from the strobe cycle: it is high in the ack cycle, and i_fifo_data is sampled into o_wb_data in the strobe cycle.
- o_fifo_wr and o_fifo_data are registered: they fire 1 cycle after the accepted i_smpl_stb.
- A CTRL write takes effect the cycle after the strobe. A sample strobe in the same cycle as the CTRL write uses the old state.
- Simultaneous sample write and bus pop are legal and must both occur.
- i_rst mid-operation: the state returns to IDLE and outputs take their reset values the next cycle. o_fifo_rst is not asserted by i_rst; the FIFO shares i_rst.
- o_int is registered: it updates 1 cycle after a fill, threshold or state change.

## Test plan
- Reset, write CTRL 0x80000000, send 4 strobes with data 1..4 -> 4 FIFO writes of 1..4. CTRL read gives bit 31 = 1.
- decim = 2, send 9 strobes with data 0..8 -> FIFO receives 0, 3, 6 only.
- Load 3 samples, then issue 4 back-to-back DATA reads -> returns 0x80000000|s0, |s1, |s2, then 0x00000000. Exactly 3 o_fifo_rd pulses.
- THRESH = 4, int_en = 1, feed 4 samples -> o_int rises 1 cycle after fill reaches 4. One DATA read clears it.
- Force i_fifo_err in RUN -> state HALT, no further writes, o_int = 1 with int_en set. Write CTRL 0x80000000 -> exactly one o_fifo_rst cycle, then RUN.
- Assert i_rst during RUN with a pending sample strobe -> no FIFO write, all outputs 0, CTRL read gives 0x0000 plus the current i_fifo_status.

Source files
------------

// File: rtl/wbmic_fifoctl.sv
// Wishbone-side sequencer for the MEMs-mic sample FIFO: gated/decimated sample
// writes, per-read FIFO pops, flush, overflow halt and threshold interrupt.
module wbmic_fifoctl #(
   parameter int unsigned BW = 12
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_smpl_stb,
   input  logic [BW-1:0] i_smpl_data,
   input  logic          i_wb_cyc,
   input  logic          i_wb_stb,
   input  logic          i_wb_we,
   input  logic [1:0]    i_wb_addr,
   input  logic [31:0]   i_wb_data,
   output logic          o_wb_ack,
   output logic          o_wb_stall,
   output logic [31:0]   o_wb_data,
   output logic          o_fifo_rst,
   output logic          o_fifo_wr,
   output logic [BW-1:0] o_fifo_data,
   output logic          o_fifo_rd,
   input  logic [BW-1:0] i_fifo_data,
   input  logic          i_fifo_empty_n,
   input  logic [15:0]   i_fifo_status,
   input  logic          i_fifo_err,
   output logic          o_int
);

   typedef enum logic [1:0] {IDLE, FLUSH, RUN, HALT} state_t;

   state_t        state_q, state_d;
   logic          ack_q;
   logic [31:0]   wb_data_q, rdata_d;
   logic          fifo_rst_q, fifo_wr_q, fifo_rd_q, int_q, int_d;
   logic [BW-1:0] fifo_data_q;
   logic          int_en_q;
   logic [3:0]    decim_q, dcnt_q;
   logic [13:0]   thresh_q;
   logic          bus_req, ctrl_wr, thresh_wr, data_rd, smpl_take;
   logic [13:0]   fill;
   logic          unused_wb_bits;

   assign bus_req   = i_wb_cyc & i_wb_stb;
   assign ctrl_wr   = bus_req &  i_wb_we & (i_wb_addr == 2'd0);
   assign thresh_wr = bus_req &  i_wb_we & (i_wb_addr == 2'd1);
   assign data_rd   = bus_req & ~i_wb_we & (i_wb_addr == 2'd2);
   assign fill      = i_fifo_status[15:2];
   assign smpl_take = i_smpl_stb & (state_q == RUN) & (dcnt_q == 4'd0);
   assign unused_wb_bits = ^{i_wb_data[28], i_wb_data[23:14]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         FLUSH:   state_d = RUN;
         RUN:     if (i_fifo_err) state_d = HALT;
         default: ;
      endcase
      // A CTRL write overrides the autonomous transitions above.
      if (ctrl_wr) begin
         if (!i_wb_data[31]) begin
            state_d = IDLE;
         end else begin
            case (state_q)
               IDLE:    state_d = i_wb_data[30] ? FLUSH : RUN;
               HALT:    state_d = FLUSH;
               default: if (i_wb_data[30]) state_d = FLUSH;
            endcase
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      case (i_wb_addr)
         2'd0: begin
            rdata_d[31]    = (state_q == RUN) || (state_q == FLUSH);
            rdata_d[30]    = (state_q == HALT);
            rdata_d[29]    = int_en_q;
            rdata_d[28]    = int_q;
            rdata_d[27:24] = decim_q;
            rdata_d[15:0]  = i_fifo_status;
         end
         2'd1: rdata_d[13:0] = thresh_q;
         2'd2: begin
            if (i_fifo_empty_n) begin
               rdata_d[31]     = 1'b1;
               rdata_d[BW-1:0] = i_fifo_data;
            end
         end
         default: ;
      endcase
   end

   assign int_d = int_en_q && (((fill >= thresh_q) && (thresh_q != 14'd0)) || (state_q == HALT));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         ack_q       <= 1'b0;
         wb_data_q   <= '0;
         fifo_rst_q  <= 1'b0;
         fifo_wr_q   <= 1'b0;
         fifo_rd_q   <= 1'b0;
         fifo_data_q <= '0;
         int_q       <= 1'b0;
         int_en_q    <= 1'b0;
         decim_q     <= '0;
         dcnt_q      <= '0;
         thresh_q    <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= bus_req;
         fifo_rst_q <= (state_d == FLUSH);
         fifo_rd_q  <= data_rd & i_fifo_empty_n;
         fifo_wr_q  <= smpl_take;
         int_q      <= int_d;
         if (bus_req && !i_wb_we) wb_data_q <= rdata_d;
         if (smpl_take) fifo_data_q <= i_smpl_data;
         if (ctrl_wr) begin
            int_en_q <= i_wb_data[29];
            decim_q  <= i_wb_data[27:24];
         end
         if (thresh_wr) thresh_q <= i_wb_data[13:0];
         // Entry straight from a CTRL write must see the decim being written now.
         if ((state_d == RUN) && (state_q != RUN))
            dcnt_q <= ctrl_wr ? i_wb_data[27:24] : decim_q;
         else if ((state_q == RUN) && i_smpl_stb)
            dcnt_q <= (dcnt_q == 4'd0) ? decim_q : dcnt_q - 4'd1;
      end
   end

   assign o_wb_ack    = ack_q;
   assign o_wb_stall  = 1'b0;
   assign o_wb_data   = wb_data_q;
   assign o_fifo_rst  = fifo_rst_q;
   assign o_fifo_wr   = fifo_wr_q;
   assign o_fifo_data = fifo_data_q;
   assign o_fifo_rd   = fifo_rd_q;
   assign o_int       = int_q;

endmodule

// File: tb/tb_wbmic_fifoctl.sv
// Directed bench for wbmic_fifoctl with a behavioural sample FIFO on its ports.
module tb_wbmic_fifoctl;

   localparam int unsigned BW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          smpl_stb = 1'b0;
   logic [BW-1:0] smpl_data = '0;
   logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [1:0]    addr = '0;
   logic [31:0]   wdat = '0;
   logic          wb_ack, wb_stall;
   logic [31:0]   wb_rdata;
   logic          fifo_rst, fifo_wr, fifo_rd, irq;
   logic [BW-1:0] fifo_wdata;
   logic [BW-1:0] fifo_head = '0;
   logic          fifo_empty_n = 1'b0;
   logic [13:0]   fifo_fill = '0;
   logic [15:0]   fifo_status;
   logic          err_q = 1'b0;
   logic          err_force = 1'b0;

   logic [BW-1:0] fq[$];
   logic [BW-1:0] wr_log[$];
   int            rd_cnt = 0;
   int            rst_cnt = 0;
   int            n_checks = 0;
   int            n_err = 0;

   assign fifo_status = {fifo_fill, (fifo_fill >= 14'd8), fifo_empty_n};

   always #5 clk = ~clk;

   wbmic_fifoctl #(.BW(BW)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_smpl_stb     (smpl_stb),
      .i_smpl_data    (smpl_data),
      .i_wb_cyc       (cyc),
      .i_wb_stb       (stb),
      .i_wb_we        (we),
      .i_wb_addr      (addr),
      .i_wb_data      (wdat),
      .o_wb_ack       (wb_ack),
      .o_wb_stall     (wb_stall),
      .o_wb_data      (wb_rdata),
      .o_fifo_rst     (fifo_rst),
      .o_fifo_wr      (fifo_wr),
      .o_fifo_data    (fifo_wdata),
      .o_fifo_rd      (fifo_rd),
      .i_fifo_data    (fifo_head),
      .i_fifo_empty_n (fifo_empty_n),
      .i_fifo_status  (fifo_status),
      .i_fifo_err     (err_q),
      .o_int          (irq)
   );

   // FIFO acts mid-cycle, so the head has advanced before the next strobe edge.
   always @(negedge clk) begin
      if (fifo_wr)  wr_log.push_back(fifo_wdata);
      if (fifo_rd)  rd_cnt++;
      if (fifo_rst) rst_cnt++;
      if (rst || fifo_rst) begin
         fq.delete();
         err_q = 1'b0;
      end else begin
         if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
         if (fifo_wr) fq.push_back(fifo_wdata);
         if (err_force) err_q = 1'b1;
      end
      fifo_empty_n = (fq.size() != 0);
      fifo_head    = (fq.size() != 0) ? fq[0] : '0;
      fifo_fill    = 14'(fq.size());
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdat = d;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("wr_ack", 32'(wb_ack), 32'd1);
   endtask

   task automatic wb_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      chk("rd_ack", 32'(wb_ack), 32'd1);
      chk(tag, wb_rdata, exp);
   endtask

   task automatic smpl(input logic [BW-1:0] d);
      smpl_stb = 1'b1; smpl_data = d;
      @(posedge clk); #1;
      smpl_stb = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},   32'(wb_ack),     32'd0);
      chk({tag, "_stall"}, 32'(wb_stall),   32'd0);
      chk({tag, "_data"},  wb_rdata,        32'd0);
      chk({tag, "_frst"},  32'(fifo_rst),   32'd0);
      chk({tag, "_fwr"},   32'(fifo_wr),    32'd0);
      chk({tag, "_fdat"},  32'(fifo_wdata), 32'd0);
      chk({tag, "_frd"},   32'(fifo_rd),    32'd0);
      chk({tag, "_int"},   32'(irq),        32'd0);
   endtask

   initial begin
      int base;
      int rc;
      logic [31:0] rexp [4];

      tick(3);
      chk_all_zero("reset");
      rst = 1'b0;
      tick(1);

      wb_wr(2'd0, 32'h8000_0000);
      base = wr_log.size();
      for (int i = 1; i <= 4; i++) smpl(BW'(i));
      tick(2);
      chk("t1_nwr", 32'(wr_log.size() - base), 32'd4);
      for (int i = 0; i < 4; i++) chk("t1_wr", 32'(wr_log[base + i]), 32'(i + 1));
      wb_rd(2'd0, 32'h8000_0011, "t1_ctrl");

      wb_wr(2'd0, 32'h8200_0000);
      base = wr_log.size();
      for (int i = 0; i < 9; i++) smpl(BW'(i));
      tick(2);
      chk("dec_nwr", 32'(wr_log.size() - base), 32'd3);
      for (int i = 0; i < 3; i++) chk("dec_wr", 32'(wr_log[base + i]), 32'(3 * i));

      rc = rst_cnt;
      wb_wr(2'd0, 32'hC000_0000);
      tick(3);
      chk("flush_pulses", 32'(rst_cnt - rc), 32'd1);
      wb_rd(2'd0, 32'h8000_0000, "flush_ctrl");

      smpl(BW'(12'h0A1));
      smpl(BW'(12'h0B2));
      smpl(BW'(12'hFFF));
      tick(2);
      rc = rd_cnt;
      rexp[0] = 32'h8000_00A1;
      rexp[1] = 32'h8000_00B2;
      rexp[2] = 32'h8000_0FFF;
      rexp[3] = 32'h0000_0000;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd2;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("b2b_ack", 32'(wb_ack), 32'd1);
         chk("b2b_data", wb_rdata, rexp[i]);
      end
      cyc = 1'b0; stb = 1'b0;
      tick(2);
      chk("b2b_pops", 32'(rd_cnt - rc), 32'd3);

      wb_wr(2'd1, 32'hFFFF_C004);
      wb_rd(2'd1, 32'h0000_0004, "thresh_rd");
      wb_wr(2'd0, 32'hA000_0000);
      for (int i = 1; i <= 3; i++) begin
         smpl(BW'(i));
         tick(1);
      end
      tick(2);
      chk("int_below", 32'(irq), 32'd0);
      smpl(BW'(4));
      chk("int_pre", 32'(irq), 32'd0);
      tick(1);
      chk("int_rise", 32'(irq), 32'd1);
      wb_rd(2'd0, 32'hB000_0011, "int_ctrl");
      wb_rd(2'd2, 32'h8000_0001, "int_pop");
      tick(1);
      chk("int_clr", 32'(irq), 32'd0);

      base = wr_log.size();
      err_force = 1'b1;
      tick(1);
      err_force = 1'b0;
      smpl(BW'(12'h077));
      tick(2);
      chk("halt_nwr", 32'(wr_log.size() - base), 32'd0);
      chk("halt_int", 32'(irq), 32'd1);
      wb_rd(2'd0, 32'h7000_000D, "halt_ctrl");
      rc = rst_cnt;
      wb_wr(2'd0, 32'h8000_0000);
      tick(3);
      chk("rerun_pulses", 32'(rst_cnt - rc), 32'd1);
      wb_rd(2'd0, 32'h8000_0000, "rerun_ctrl");
      chk("rerun_int", 32'(irq), 32'd0);
      base = wr_log.size();
      smpl(BW'(12'h123));
      tick(2);
      chk("rerun_nwr", 32'(wr_log.size() - base), 32'd1);
      chk("rerun_wr", 32'(wr_log[base]), 32'h123);

      base = wr_log.size();
      rst = 1'b1; smpl_stb = 1'b1; smpl_data = BW'(12'h555);
      @(posedge clk); #1;
      rst = 1'b0; smpl_stb = 1'b0;
      chk_all_zero("midrst");
      tick(2);
      chk("midrst_nwr", 32'(wr_log.size() - base), 32'd0);
      wb_rd(2'd0, 32'h0000_0000, "midrst_ctrl");
      smpl(BW'(12'h321));
      tick(2);
      chk("idle_drop", 32'(wr_log.size() - base), 32'd0);

      wb_rd(2'd3, 32'h0000_0000, "addr3");
      stb = 1'b1; cyc = 1'b0; addr = 2'd0;
      @(posedge clk); #1;
      stb = 1'b0;
      chk("nocyc_ack", 32'(wb_ack), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
